// File: rtl/instruction_fetch_unit_if.sv
// Instruction-read bus between the fetch sequencer and memory / instruction register.
interface instruction_fetch_unit_if;
   logic        busEnable;
   logic [31:0] busAddress;
   logic        busWait;
   logic        instructionWriteEnable;

   modport master (
      output busEnable,
      output busAddress,
      output instructionWriteEnable,
      input  busWait
   );

   modport slave (
      input  busEnable,
      input  busAddress,
      input  instructionWriteEnable,
      output busWait
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: holds pc, issues one instruction read per instruction, waits for execute.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect targets raise a fault).
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR   = 32'hE0000000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                     clock,
   input  logic                     resetN,
   instruction_fetch_unit_if.master bus,
   input  logic                     executeDone,
   input  logic                     redirectValid,
   input  logic [31:0]              redirectTarget,
   output logic [31:0]              pc,
   output logic [31:0]              pcPlus4,
   output logic                     instructionValid,
   output logic                     fetchFault
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StFetch   = 2'd1;
   localparam logic [1:0] StExecute = 2'd2;
   localparam logic [1:0] StFault   = 2'd3;

   localparam logic [7:0] CountLast = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [7:0]  count_q, count_d;

   logic [31:0] redirect_pc;
   logic        redirect_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
   assign redirect_pc         = redirectTarget;
   assign redirect_misaligned = |redirectTarget[1:0];
`else
   assign redirect_pc         = redirectTarget & 32'hFFFF_FFFC;
   assign redirect_misaligned = 1'b0;
`endif

   assign pc                         = pc_q;
   assign pcPlus4                    = pc_q + 32'd4;
   assign bus.busAddress             = pc_q;
   assign bus.busEnable              = (state_q == StFetch);
   // Write strobe comes straight from state so an async reset kills it in the same cycle.
   assign bus.instructionWriteEnable = (state_q == StFetch) && !bus.busWait;
   assign instructionValid           = (state_q == StExecute);
   assign fetchFault                 = (state_q == StFault);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (!bus.busWait) begin
               state_d = StExecute;
               count_d = 8'd0;
            end else if (count_q == CountLast) begin
               state_d = StFault;
               count_d = 8'd0;
            end else begin
               count_d = count_q + 8'd1;
            end
         end
         StExecute: begin
            if (executeDone) begin
               if (redirectValid) begin
                  pc_d    = redirect_pc;
                  state_d = redirect_misaligned ? StFault : StFetch;
               end else begin
                  pc_d    = pcPlus4;
                  state_d = StFetch;
               end
            end
         end
         StFault: begin
            if (executeDone && redirectValid) begin
               pc_d    = redirect_pc;
               state_d = redirect_misaligned ? StFault : StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         pc_q    <= RESET_VECTOR;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch sequencer that sits directly upstream of the current instruction register. Holds the program counter, issues one 32-bit instruction read per instruction on the CPU bus, and pulses the instruction register's write-enable in the cycle the read data is valid. Then waits for the execute stage to finish before computing the next fetch address, either sequential or redirected. A bus-wait timeout converts a hung fetch into a fault.

## Interface
Parameters:
- RESET_VECTOR, 32'hE0000000, PC value loaded by reset
- TIMEOUT_CYCLES, 16, consecutive busWait cycles in FETCH that raise a fault (legal range 2..255)

Ports:
- clock  input  1  the clock
- resetN  input  1  asynchronous, active-low reset
- busEnable  output  1  read request; equals 1 exactly in state FETCH
- busAddress  output  32  fetch address; equals pc
- busWait  input  1  1 = read not yet complete in this cycle
- instructionWriteEnable  output  1  combinational pulse: FETCH && !busWait; drives the instruction register write-enable, which loads busReadData directly
- executeDone  input  1  execute stage finished the current instruction
- redirectValid  input  1  with executeDone: next PC is redirectTarget
- redirectTarget  input  32  branch, jump or exception target
- pc  output  32  address of current or pending instruction
- pcPlus4  output  32  pc + 4, mod 2^32
- instructionValid  output  1  1 in state EXECUTE
- fetchFault  output  1  1 in state FAULT

## Operation
- States: IDLE, FETCH, EXECUTE, FAULT. 2-bit state register and 8-bit timeout counter, both asynchronously reset.
- Reset values: state=IDLE, pc=RESET_VECTOR, counter=0. busEnable, instructionWriteEnable, instructionValid and fetchFault are 0. busAddress=RESET_VECTOR.
- IDLE -> FETCH unconditionally on the first clock edge with resetN=1.
- FETCH, busWait=0 -> EXECUTE. instructionWriteEnable=1 during that cycle. Counter cleared.
- FETCH, busWait=1 -> counter+1. If the counter already equals TIMEOUT_CYCLES-1, go to FAULT instead and clear the counter. pc is unchanged.
- EXECUTE, executeDone=1:
  - redirectValid=0 -> pc <= pcPlus4, wrapping 32'hFFFFFFFC -> 0.
  - redirectValid=1 -> pc <= redirectTarget.
  - Either way, state -> FETCH.
- EXECUTE, executeDone=0 -> hold. No bus activity.
- FAULT: busEnable=0. executeDone=1 with redirectValid=1 -> pc <= redirectTarget, state -> FETCH. All other inputs are ignored. This is the exception-entry path.
- executeDone and redirectValid are ignored in IDLE and FETCH.
- busReadData is not registered here. Its only consumer is the instruction register.

## Timing
- Zero-wait bus: FETCH lasts 1 cycle, so the minimum instruction period is 2 cycles (FETCH + 1 EXECUTE cycle with executeDone=1).
- N wait cycles extend FETCH to N+1 cycles.
- With busWait held at 1, FAULT is entered at the edge ending the TIMEOUT_CYCLES-th FETCH cycle.
- A new pc appears on the edge leaving EXECUTE and drives busAddress in the very next cycle.
- resetN assertion mid-FETCH drops busEnable immediately, asynchronously through state. A completed read must not write the instruction register.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirectTarget[1:0] != 0 loads pc with the unmodified target and enters FAULT instead of FETCH.
  - No bus read is issued.
- FETCH_ALIGN_CHECK_EN undefined: redirectTarget[1:0] is forced to 2'b00 when loaded into pc, and the redirect proceeds to FETCH.
- Sequential pc increments stay aligned in both builds.

## Test plan
- Reset release, zero-wait bus, executeDone held 1 -> busAddress sequence E0000000, E0000004, E0000008. instructionWriteEnable is 1 every other cycle.
- busWait=1 for 3 cycles at E0000000 -> busEnable held for 4 cycles, then a single instructionWriteEnable pulse, then instructionValid=1.
- busWait held 1 with TIMEOUT_CYCLES=16 -> fetchFault=1 at cycle 16 of FETCH and busEnable=0. Redirect to 00000100 -> fetch at 00000100.
- In EXECUTE at pc=FFFFFFFC, executeDone=1 with no redirect -> next busAddress 00000000.
- Redirect to 00001002:
  - With FETCH_ALIGN_CHECK_EN: fetchFault=1, pc=00001002, no bus request.
  - Without: fetch at 00001000.
- resetN pulled low in the second wait cycle of a fetch -> busEnable=0 immediately and pc=E0000000. After release, a single fetch at E0000000.
